bin_to_bcd_converter: RTL and testbench

BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

---
 rtl/bcd_pkg.sv | 6 +
 rtl/bcd_add3.sv | 9 +
 rtl/bin_to_bcd_converter.sv | 70 +++++++
 tb/tb_bin_to_bcd_converter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states and digit constants for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESHOLD = 5;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = (d >= BCD_DIGIT_W'(ADD3_THRESHOLD)) ? d + BCD_DIGIT_W'(3) : d;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble, one bit per cycle, registered BCD result
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Start,
  input  logic [BIN_WIDTH-1:0]          Binary,
  output logic                          Busy,
  output logic                          Done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  if ((64'(10) ** DIGITS) <= ((64'(1) << BIN_WIDTH) - 64'(1))) begin : g_range_err
    $error("DIGITS too small for BIN_WIDTH");
  end
  state_t               state, state_n;
  logic [SW-1:0]        scratch, fixed, scratch_n;
  logic [BIN_WIDTH-1:0] bin;
  logic [CW-1:0]        cnt;
  logic                 last, busy_n, done_n;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d(scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q(fixed[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  assign scratch_n = SW'({fixed, bin[BIN_WIDTH-1]});
  assign last = cnt == CW'(1);
  // the final shift writes its result straight to BCD so DONE can accept the next Start
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      Busy  <= busy_n;
      Done  <= done_n;
    end
  end
  always_comb begin
    state_n = (state == SHIFT) ? (last ? DONE : SHIFT) : (Start ? SHIFT : IDLE);
  end
  always_comb begin
    busy_n = state_n == SHIFT;
    done_n = (state == SHIFT) && last;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scratch <= '0;
      bin     <= '0;
      cnt     <= '0;
      BCD     <= '0;
    end else if (state == SHIFT) begin
      scratch <= scratch_n;
      bin     <= bin << 1;
      cnt     <= cnt - CW'(1);
      if (last) BCD <= scratch_n;
    end else if (Start) begin
      scratch <= '0;
      bin     <= Binary;
      cnt     <= CW'(BIN_WIDTH);
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: transaction-level model plus per-cycle compare and directed scenarios
module tb_bin_to_bcd_converter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Binary = 8'd0;
  logic        Busy, Done;
  logic [11:0] BCD;
  int total = 0;
  int bad = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;
  int remain = 0;
  logic [7:0]  held = 8'd0;
  logic [11:0] exp_bcd = 12'd0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  bin_to_bcd_converter #(.BIN_WIDTH(8), .DIGITS(3)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(Start), .Binary(Binary),
    .Busy(Busy), .Done(Done), .BCD(BCD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // a request is accepted when no conversion is pending; the result appears 8 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_bcd = '0;
    end else begin
      exp_done = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          exp_bcd = to_bcd(int'(held));
          exp_done = 1'b1;
        end
      end else if (Start) begin
        held = Binary;
        remain = 8;
      end
      exp_busy = remain > 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(Busy), 32'(exp_busy));
      check("done", 32'(Done), 32'(exp_done));
      check("bcd", 32'(BCD), 32'(exp_bcd));
      check("busy_done_excl", 32'(Busy && Done), 32'd0);
      for (int i = 0; i < 3; i++) check("digit_range", 32'(BCD[i*4 +: 4] <= 4'd9), 32'd1);
    end
  end

  task automatic run(input logic [7:0] v, input int alt, input logic [11:0] want, input string nm);
    int e, b;
    bit got;
    @(negedge clk);
    Start = 1'b1;
    Binary = v;
    @(negedge clk);
    Start = 1'b0;
    e = 1;
    b = int'(Busy);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i == 1 && alt >= 0) Binary = alt[7:0];
      @(negedge clk);
      e++;
      if (Busy) b++;
      if (Done) got = 1'b1;
    end
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    check({nm, "_latency"}, 32'(e), 32'd9);
    check({nm, "_busy_cycles"}, 32'(b), 32'd8);
    check({nm, "_result"}, 32'(BCD), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    bit got;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_bcd", 32'(BCD), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("model_255", 32'(to_bcd(255)), 32'h255);
    check("model_99", 32'(to_bcd(99)), 32'h099);
    check("model_0", 32'(to_bcd(0)), 32'h000);
    run(8'd255, -1, 12'h255, "max");
    run(8'd0, -1, 12'h000, "zero");
    run(8'd99, -1, 12'h099, "n99");
    // Start held high: back-to-back conversions, extra Start during Busy ignored
    @(negedge clk);
    Start = 1'b1;
    Binary = 8'd10;
    last = 0;
    for (int r = 0; r < 3; r++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (Done) got = 1'b1;
      end
      check("stream_done_seen", 32'(got), 32'd1);
      check("stream_result", 32'(BCD), r == 0 ? 32'h010 : r == 1 ? 32'h011 : 32'h012);
      if (r > 0) check("stream_period", 32'(edge_n - last), 32'd9);
      last = edge_n;
      Binary = 8'(11 + r);
      if (r == 2) Start = 1'b0;
    end
    repeat (10) @(negedge clk);
    run(8'd200, 7, 12'h200, "input_change");
    // abort mid-conversion with an asynchronous reset
    @(negedge clk);
    Start = 1'b1;
    Binary = 8'd77;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_bcd", 32'(BCD), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done_bcd", 32'(BCD), 32'd0);
    run(8'd128, -1, 12'h128, "after_reset");
    for (int v = 0; v < 256; v++) run(8'(v), -1, to_bcd(v), "sweep");
    repeat (400) begin
      @(negedge clk);
      Start = ($urandom_range(0, 3) == 0);
      Binary = 8'($urandom);
    end
    @(negedge clk);
    Start = 1'b0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
